fetch_unit: RTL

//  Instruction fetch stage of the unpipelined WISC processor; feeds decode0.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - WISC instruction fetch stage: PC/IR ownership and the imem req/rdy handshake
// Optional FETCH_PERF_EN builds the saturating fetch/stall counters.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_INC    = 16'd2,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_rdy,
  input  logic [15:0] i_imem_data,
  output logic [15:0] o_instr,
  output logic        o_instr_valid,
  output logic [15:0] o_pc_out,
  output logic [15:0] o_pc_plus2,
  input  logic        i_done,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_halted,
  output logic        o_err,
  output logic [15:0] o_fetch_cnt,
  output logic [15:0] o_stall_cnt
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic        r_instr_valid;
  logic        r_err;
  logic        w_in_req;

  assign w_in_req = (r_state == S_REQ);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (i_imem_rdy) begin
            r_instr       <= i_imem_data;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // halt outranks a misaligned redirect, which outranks a normal redirect
          if (i_done) begin
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            if (i_halt) begin
              r_state <= S_HALT;
            end else if (i_redirect && i_redirect_pc[0]) begin
              r_err   <= 1'b1;
              r_state <= S_HALT;
            end else if (i_redirect) begin
              r_pc    <= i_redirect_pc;
              r_state <= S_REQ;
            end else begin
              r_pc    <= r_pc + PC_INC;
              r_state <= S_REQ;
            end
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign o_imem_req    = w_in_req;
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_pc_out      = r_pc;
  assign o_pc_plus2    = r_pc + PC_INC;
  assign o_halted      = (r_state == S_HALT);
  assign o_err         = r_err;

`ifdef FETCH_PERF_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_stall_cnt;

  // Counters only move in S_REQ, so they freeze naturally once halted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_cnt <= 16'h0000;
      r_stall_cnt <= 16'h0000;
    end else if (w_in_req) begin
      if (i_imem_rdy && (r_fetch_cnt != 16'hFFFF))
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (!i_imem_rdy && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_fetch_cnt = 16'h0000;
  assign o_stall_cnt = 16'h0000;
`endif

endmodule
